// File: rtl/store_merge_unit.sv
// Partial-store writer: read-modify-write for byte/halfword stores, direct write for words.
// Optional misaligned-halfword detection is enabled by defining STORE_ALIGN_CHECK_EN.
module store_merge_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  WordouHWouByte,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddress,
  output logic        MemWr,
  output logic [31:0] MemDataOut,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWait  = 3'd2,
    StMerge = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SizeWord    = 2'b00,
    SizeHalf    = 2'b01,
    SizeByte    = 2'b10,
    SizeWordAlt = 2'b11
  } sizeKind_t;

  state_t    state, nextState;
  sizeKind_t startSize;

  // Captured request: only the low lane bits and low halfword are needed,
  // word stores are written straight from StoreData at capture time.
  sizeKind_t   reqSize;
  logic [1:0]  reqLane;
  logic [15:0] reqData;

  logic [31:0] mergedWord;
  logic [31:0] nextMemAddress;
  logic [31:0] nextMemDataOut;
  logic        nextMemWr;
  logic        nextDone;
  logic        nextBusy;
  logic        startWord;
  logic        acceptStart;
`ifdef STORE_ALIGN_CHECK_EN
  logic        nextAlignErr;
  logic        startMisaligned;
`endif

  assign startSize   = sizeKind_t'(WordouHWouByte);
  assign startWord   = (startSize == SizeWord) || (startSize == SizeWordAlt);
  assign acceptStart = (state == StIdle) && Start;
`ifdef STORE_ALIGN_CHECK_EN
  assign startMisaligned = (startSize == SizeHalf) && Address[0];
`endif

  // Little-endian lane replacement into the word just read from memory.
  always_comb begin
    mergedWord = MemDataIn;
    if (reqSize == SizeHalf) begin
      if (reqLane[1]) mergedWord[31:16] = reqData;
      else            mergedWord[15:0]  = reqData;
    end else begin
      case (reqLane)
        2'd0:    mergedWord[7:0]   = reqData[7:0];
        2'd1:    mergedWord[15:8]  = reqData[7:0];
        2'd2:    mergedWord[23:16] = reqData[7:0];
        default: mergedWord[31:24] = reqData[7:0];
      endcase
    end
  end

  // Next state plus next values of the registered (Moore) outputs.
  always_comb begin
    // NOTE: every value written here gets a default first, so no latch is inferred.
    nextState      = state;
    nextMemAddress = MemAddress;
    nextMemDataOut = MemDataOut;
    nextMemWr      = 1'b0;
    nextDone       = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    nextAlignErr   = 1'b0;
`endif
    case (state)
      StIdle: begin
        if (Start) begin
          nextMemAddress = {Address[31:2], 2'b00};
          if (startWord) begin
            nextState      = StWrite;
            nextMemWr      = 1'b1;
            nextMemDataOut = StoreData;
`ifdef STORE_ALIGN_CHECK_EN
          end else if (startMisaligned) begin
            nextState    = StDone;
            nextDone     = 1'b1;
            nextAlignErr = 1'b1;
`endif
          end else begin
            nextState = StRead;
          end
        end
      end
      StRead:  nextState = StWait;
      StWait:  nextState = StMerge;
      StMerge: begin
        nextState      = StWrite;
        nextMemWr      = 1'b1;
        nextMemDataOut = mergedWord;
      end
      StWrite: begin
        nextState = StDone;
        nextDone  = 1'b1;
      end
      StDone:  nextState = StIdle;
      default: nextState = StIdle;
    endcase
    nextBusy = (nextState != StIdle);
  end

  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state      <= StIdle;
      MemAddress <= '0;
      MemDataOut <= '0;
      MemWr      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      AlignErr   <= 1'b0;
`endif
    end else begin
      state      <= nextState;
      MemAddress <= nextMemAddress;
      MemDataOut <= nextMemDataOut;
      MemWr      <= nextMemWr;
      Busy       <= nextBusy;
      Done       <= nextDone;
`ifdef STORE_ALIGN_CHECK_EN
      AlignErr   <= nextAlignErr;
`endif
    end
  end

  // NOTE: request registers carry no reset; they are always loaded before use.
  always_ff @(posedge Clock) begin
    if (acceptStart) begin
      reqSize <= startSize;
      reqLane <= Address[1:0];
      reqData <= StoreData[15:0];
    end
  end

`ifndef STORE_ALIGN_CHECK_EN
  assign AlignErr = 1'b0;
`endif

endmodule
